// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, followed by a single sign-correction cycle and a one-cycle done pulse.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mult_start,
    input  logic              div_start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi_result,
    output logic [DATA_W-1:0] lo_result,
    output logic              mult_div_done,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                is_mult_reg, is_mult_next;
    logic                sign_a_reg, sign_a_next;
    logic                sign_b_reg, sign_b_next;
    logic [DATA_W-1:0]   mag_a_reg, mag_a_next;
    logic [DATA_W-1:0]   mag_b_reg, mag_b_next;
    logic [2*DATA_W-1:0] acc_reg, acc_next;
    logic [DATA_W-1:0]   hi_reg, hi_next;
    logic [DATA_W-1:0]   lo_reg, lo_next;
    logic                done_reg, done_next;

    logic                accept;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_diff;
    logic                q_bit;
    logic [2*DATA_W-1:0] prod_neg;
    logic [DATA_W-1:0]   quot_neg;
    logic [DATA_W-1:0]   rem_neg;

    assign accept = (state_reg == IDLE) && (mult_start || div_start);

    // Multiply: mag_a is the multiplier shifted right, mag_b the multiplicand.
    assign mul_sum = {1'b0, acc_reg[2*DATA_W-1:DATA_W]}
                   + {1'b0, mag_b_reg & {DATA_W{mag_a_reg[0]}}};

    // Divide: acc holds {remainder, quotient}; mag_a feeds dividend bits MSB first.
    assign rem_shift = {acc_reg[2*DATA_W-1:DATA_W], mag_a_reg[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, mag_b_reg};
    assign q_bit     = (rem_shift >= {1'b0, mag_b_reg});

    assign prod_neg = -acc_reg;
    assign quot_neg = -acc_reg[DATA_W-1:0];
    assign rem_neg  = -acc_reg[2*DATA_W-1:DATA_W];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mult_start || div_start) state_next = CALC;
            CALC:    if (cnt_reg == CNT_LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next     = cnt_reg;
        is_mult_next = is_mult_reg;
        sign_a_next  = sign_a_reg;
        sign_b_next  = sign_b_reg;
        mag_a_next   = mag_a_reg;
        mag_b_next   = mag_b_reg;
        acc_next     = acc_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = (state_reg == FIX);

        if (accept) begin
            // Multiply wins when both requests arrive together.
            is_mult_next = mult_start;
            sign_a_next  = op_a[DATA_W-1];
            sign_b_next  = op_b[DATA_W-1];
            mag_a_next   = op_a[DATA_W-1] ? -op_a : op_a;
            mag_b_next   = op_b[DATA_W-1] ? -op_b : op_b;
            acc_next     = '0;
            cnt_next     = '0;
        end else if (state_reg == CALC) begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (is_mult_reg) begin
                acc_next   = {mul_sum, acc_reg[DATA_W-1:1]};
                mag_a_next = mag_a_reg >> 1;
            end else begin
                acc_next[2*DATA_W-1:DATA_W] = q_bit ? rem_diff[DATA_W-1:0]
                                                    : rem_shift[DATA_W-1:0];
                acc_next[DATA_W-1:0]        = {acc_reg[DATA_W-2:0], q_bit};
                mag_a_next                  = mag_a_reg << 1;
            end
        end else if (state_reg == FIX) begin
            if (is_mult_reg) begin
                {hi_next, lo_next} = (sign_a_reg ^ sign_b_reg) ? prod_neg : acc_reg;
            end else begin
                lo_next = (sign_a_reg ^ sign_b_reg) ? quot_neg : acc_reg[DATA_W-1:0];
                hi_next = sign_a_reg ? rem_neg : acc_reg[2*DATA_W-1:DATA_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            is_mult_reg <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            mag_a_reg   <= '0;
            mag_b_reg   <= '0;
            acc_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            is_mult_reg <= is_mult_next;
            sign_a_reg  <= sign_a_next;
            sign_b_reg  <= sign_b_next;
            mag_a_reg   <= mag_a_next;
            mag_b_reg   <= mag_b_next;
            acc_reg     <= acc_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
        end
    end

    assign hi_result     = hi_reg;
    assign lo_result     = lo_reg;
    assign mult_div_done = done_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random operations compared
// cycle by cycle against a plain-arithmetic signed multiply/divide model.
module tb_mult_div_unit;
    logic        CLK = 1'b0;
    logic        RST;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi_result;
    logic [31:0] lo_result;
    logic        mult_div_done;
    logic        busy;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] prev_hi   = '0;
    logic [31:0] prev_lo   = '0;

    mult_div_unit #(.DATA_W(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .op_a          (op_a),
        .op_b          (op_b),
        .hi_result     (hi_result),
        .lo_result     (lo_result),
        .mult_div_done (mult_div_done),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Signed reference: 64-bit product, truncating division, documented divide-by-zero result.
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            hi = a;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, input bit inj_m, input bit inj_d, input int rst_k);
        logic [31:0] eh, el;
        int          dones;
        bit          aborted;
        model(m, a, b, eh, el);
        @(negedge CLK);
        mult_start = m;
        div_start  = d;
        op_a       = a;
        op_b       = b;
        @(negedge CLK);
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        dones      = 0;
        for (int k = 1; k <= 35; k++) begin
            aborted = (rst_k != 0) && (k > rst_k);
            check("busy", {63'd0, busy}, {63'd0, (!aborted && k <= 34)});
            check("done", {63'd0, mult_div_done}, {63'd0, (!aborted && k == 34)});
            if (mult_div_done) dones++;
            if (aborted) begin
                check("hi_abort", {32'd0, hi_result}, 64'd0);
                check("lo_abort", {32'd0, lo_result}, 64'd0);
            end else if (k >= 34) begin
                check("hi_result", {32'd0, hi_result}, {32'd0, eh});
                check("lo_result", {32'd0, lo_result}, {32'd0, el});
            end else begin
                check("hi_hold", {32'd0, hi_result}, {32'd0, prev_hi});
                check("lo_hold", {32'd0, lo_result}, {32'd0, prev_lo});
            end
            mult_start = 1'b0;
            div_start  = 1'b0;
            RST        = 1'b0;
            if (k == inj_k) begin
                mult_start = inj_m;
                div_start  = inj_d;
            end
            if (k == rst_k) RST = 1'b1;
            @(negedge CLK);
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
        check("done_count", 64'(dones), (rst_k == 0) ? 64'd1 : 64'd0);
        if (rst_k != 0) begin
            prev_hi = '0;
            prev_lo = '0;
        end else begin
            prev_hi = eh;
            prev_lo = el;
        end
        $display("%s a=%h b=%h -> hi=%h lo=%h (expected hi=%h lo=%h)%s",
                 m ? "MULT" : "DIV ", a, b, hi_result, lo_result,
                 prev_hi, prev_lo, (rst_k != 0) ? " aborted by reset" : "");
    endtask

    logic [31:0] specials [6];

    initial begin
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        specials[5] = 32'h0000_0002;

        RST        = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge CLK);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, mult_div_done}, 64'd0);
        check("reset_hi", {32'd0, hi_result}, 64'd0);
        check("reset_lo", {32'd0, lo_result}, 64'd0);
        RST = 1'b0;

        run_op(1, 0, 32'd7,          32'hFFFF_FFFD, 0, 0, 0, 0);
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0);
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2,          0, 0, 0, 0);
        run_op(0, 1, 32'd7,          32'hFFFF_FFFE, 0, 0, 0, 0);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(0, 1, 32'd5,          32'd0,          0, 0, 0, 0);
        run_op(0, 1, 32'd0,          32'd0,          0, 0, 0, 0);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd0,          0, 0, 0, 0);
        run_op(1, 1, 32'd6,          32'd4,          0, 0, 0, 0);
        run_op(1, 0, 32'd9,          32'd11,         10, 0, 1, 0);
        run_op(0, 1, 32'd100,        32'd7,          34, 1, 0, 0);
        run_op(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 15);
        run_op(1, 0, 32'd3,          32'd5,          0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            bit          m, d;
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            m = $urandom_range(0, 1) == 1;
            d = !m || ($urandom_range(0, 4) == 0);
            run_op(m, d, a, b, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
